// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared encoder classes, RV32 opcodes and the canonical NOP word.
// Build option: INSTR_ENCODER_MULDIV_EN enables MULDIV encoding in instr_field_packer.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        ENC_R      = 4'd0,
        ENC_I      = 4'd1,
        ENC_LOAD   = 4'd2,
        ENC_STORE  = 4'd3,
        ENC_BRANCH = 4'd4,
        ENC_JAL    = 4'd5,
        ENC_JALR   = 4'd6,
        ENC_LUI    = 4'd7,
        ENC_AUIPC  = 4'd8,
        ENC_SYSTEM = 4'd9,
        ENC_MULDIV = 4'd10,
        ENC_LI     = 4'd11,
        ENC_NOP    = 4'd12
    } EncClass_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational class+fields to single RV32 word packing.
// Build option: INSTR_ENCODER_MULDIV_EN makes MULDIV a supported class.
module instr_field_packer
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  EncClass_t   i_cls,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7b5,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_err
);

    logic [24:0] w_ifmt;

    assign w_ifmt = {i_imm[11:0], i_rs1, i_funct3, i_rd};

    // Field placement per instruction format; anything unrecognised degrades to NOP with error.
    always_comb begin
        o_word = NOP_WORD;
        o_err  = 1'b0;
        case (i_cls)
            ENC_R:      o_word = {1'b0, i_funct7b5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OPC_OP};
            ENC_I:      o_word = {i_imm[11], (i_funct3 == 3'b101) ? i_funct7b5 : i_imm[10],
                                  i_imm[9:0], i_rs1, i_funct3, i_rd, OPC_OP_IMM};
            ENC_LOAD:   o_word = {w_ifmt, OPC_LOAD};
            ENC_JALR:   o_word = {w_ifmt, OPC_JALR};
            ENC_SYSTEM: o_word = {w_ifmt, OPC_SYSTEM};
            ENC_STORE:  o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
            ENC_BRANCH: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                  i_imm[4:1], i_imm[11], OPC_BRANCH};
            ENC_JAL:    o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
            ENC_LUI:    o_word = {i_imm[31:12], i_rd, OPC_LUI};
            ENC_AUIPC:  o_word = {i_imm[31:12], i_rd, OPC_AUIPC};
            ENC_NOP:    o_word = NOP_WORD;
`ifdef INSTR_ENCODER_MULDIV_EN
            ENC_MULDIV: o_word = {7'b0000001, i_rs2, i_rs1, i_funct3, i_rd, OPC_OP};
`endif
            default:    o_err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: registered field-to-instruction encoder with LI expansion and valid/ready handshakes.
// Build option: INSTR_ENCODER_MULDIV_EN (passed through to instr_field_packer).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter bit          LI_FIXED_LEN = 1'b0,
    parameter logic [31:0] NOP_WORD     = NOP_INSTR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_class,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic        req_funct7b5,
    input  logic [31:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic        instr_last,
    output logic        enc_err
);

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2_PEND} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_valid;
    logic [31:0] r_data;
    logic        r_last;
    logic        r_err;
    logic [4:0]  r_li_rd;
    logic [11:0] r_li_lo;

    EncClass_t   w_req_cls;
    logic        w_hs;
    logic        w_acc;
    logic        w_load2;
    logic        w_is_li;
    logic        w_li_one;
    logic        w_li_two;
    logic [19:0] w_li_hi;

    EncClass_t   w_p_cls;
    logic [4:0]  w_p_rd;
    logic [4:0]  w_p_rs1;
    logic [2:0]  w_p_funct3;
    logic        w_p_funct7b5;
    logic [31:0] w_p_imm;
    logic [31:0] w_p_word;
    logic        w_p_err;

    assign w_req_cls = EncClass_t'(req_class);
    assign w_hs      = r_valid & instr_ready;
    assign req_ready = !r_valid | (instr_ready & r_last & (r_state != EMIT2_PEND));
    assign w_acc     = req_valid & req_ready;
    // Only an LI first word is ever presented with last=0, so this marks the second-word load.
    assign w_load2   = w_hs & (r_state == EMIT1) & !r_last;

    // Rounded upper part so that LUI hi + sext(lo) reconstructs the value (wraps at 32 bits).
    assign w_is_li  = (w_req_cls == ENC_LI);
    assign w_li_hi  = req_imm[31:12] + {19'b0, req_imm[11]};
    assign w_li_one = (req_imm[31:11] == {21{req_imm[31]}}) & !LI_FIXED_LEN;
    assign w_li_two = w_is_li & !w_li_one & ((req_imm[11:0] != 12'd0) | LI_FIXED_LEN);

    // Packer input: the queued ADDI for an LI second word, else the (LI-lowered) request.
    always_comb begin
        w_p_cls      = w_req_cls;
        w_p_rd       = req_rd;
        w_p_rs1      = req_rs1;
        w_p_funct3   = req_funct3;
        w_p_funct7b5 = req_funct7b5;
        w_p_imm      = req_imm;
        if (w_load2) begin
            w_p_cls      = ENC_I;
            w_p_rd       = r_li_rd;
            w_p_rs1      = r_li_rd;
            w_p_funct3   = 3'b000;
            w_p_funct7b5 = 1'b0;
            w_p_imm      = {{20{r_li_lo[11]}}, r_li_lo};
        end else if (w_is_li) begin
            w_p_cls      = w_li_one ? ENC_I : ENC_LUI;
            w_p_rs1      = 5'd0;
            w_p_funct3   = 3'b000;
            w_p_funct7b5 = 1'b0;
            w_p_imm      = w_li_one ? req_imm : {w_li_hi, 12'd0};
        end
    end

    instr_field_packer #(
        .NOP_WORD   (NOP_WORD)
    ) u_packer (
        .i_cls      (w_p_cls),
        .i_rd       (w_p_rd),
        .i_rs1      (w_p_rs1),
        .i_rs2      (req_rs2),
        .i_funct3   (w_p_funct3),
        .i_funct7b5 (w_p_funct7b5),
        .i_imm      (w_p_imm),
        .o_word     (w_p_word),
        .o_err      (w_p_err)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       w_state_nxt = w_acc ? EMIT1 : IDLE;
            EMIT1:      if (w_hs) w_state_nxt = !r_last ? EMIT2_PEND : (w_acc ? EMIT1 : IDLE);
            EMIT2_PEND: w_state_nxt = w_hs ? IDLE : EMIT2_PEND;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Output word register; holds while stalled, returns to NOP when drained.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= NOP_WORD;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_load2) begin
            r_valid <= 1'b1;
            r_data  <= w_p_word;
            r_last  <= 1'b1;
            r_err   <= w_p_err;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_data  <= w_p_word;
            r_last  <= !w_li_two;
            r_err   <= w_p_err;
        end else if (w_hs) begin
            r_valid <= 1'b0;
            r_data  <= NOP_WORD;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    // Capture the LI destination and low immediate for the second word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_li_rd <= 5'd0;
            r_li_lo <= 12'd0;
        end else if (w_acc) begin
            r_li_rd <= req_rd;
            r_li_lo <= req_imm[11:0];
        end
    end

    assign instr_valid = r_valid;
    assign instr_data  = r_data;
    assign instr_last  = r_last;
    assign enc_err     = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder (default and LI_FIXED_LEN=1).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rv = 1'b0, rv1 = 1'b0;
    logic        rr, rr1;
    logic [3:0]  cls = 4'd12;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]  f3 = 3'd0;
    logic        f7 = 1'b0;
    logic [31:0] imm = 32'd0;
    logic        iv, iv1;
    logic        ir = 1'b1, ir1 = 1'b1;
    logic [31:0] d, d1;
    logic        last, last1, err, err1;
    int          ntests = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .resetn(resetn), .req_valid(rv), .req_ready(rr), .req_class(cls),
        .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2), .req_funct3(f3), .req_funct7b5(f7),
        .req_imm(imm), .instr_valid(iv), .instr_ready(ir), .instr_data(d),
        .instr_last(last), .enc_err(err)
    );

    instr_encoder #(.LI_FIXED_LEN(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .req_valid(rv1), .req_ready(rr1), .req_class(cls),
        .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2), .req_funct3(f3), .req_funct7b5(f7),
        .req_imm(imm), .instr_valid(iv1), .instr_ready(ir1), .instr_data(d1),
        .instr_last(last1), .enc_err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setf(input logic [3:0] c, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] e, input logic [2:0] f, input logic g, input logic [31:0] i);
        cls = c; rd = a; rs1 = b; rs2 = e; f3 = f; f7 = g; imm = i;
    endtask

    // Present one request to dut, check it is accepted, and check the first word.
    task automatic send(input string tag, input logic [31:0] w, input logic l, input logic e);
        rv = 1'b1;
        chk({tag, ".rdy"}, {31'd0, rr}, 32'd1);
        tick();
        rv = 1'b0;
        chk({tag, ".v"}, {31'd0, iv}, 32'd1);
        chk({tag, ".d"}, d, w);
        chk({tag, ".last"}, {31'd0, last}, {31'd0, l});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
    endtask

    task automatic drain(input string tag);
        tick();
        chk({tag, ".idle"}, {31'd0, iv}, 32'd0);
        chk({tag, ".nop"}, d, 32'h0000_0013);
    endtask

    // LI with two words on dut, instr_ready held high.
    task automatic li2(input string tag, input logic [4:0] r, input logic [31:0] i,
                       input logic [31:0] w1, input logic [31:0] w2);
        setf(4'd11, r, 5'd0, 5'd0, 3'd0, 1'b0, i);
        send({tag, ".w1"}, w1, 1'b0, 1'b0);
        chk({tag, ".rdy1"}, {31'd0, rr}, 32'd0);
        tick();
        chk({tag, ".w2"}, d, w2);
        chk({tag, ".last2"}, {31'd0, last}, 32'd1);
        chk({tag, ".rdy2"}, {31'd0, rr}, 32'd0);
        drain(tag);
    endtask

    initial begin
        tick();
        tick();
        chk("rst.v", {31'd0, iv}, 32'd0);
        chk("rst.d", d, 32'h0000_0013);
        chk("rst.last", {31'd0, last}, 32'd0);
        chk("rst.err", {31'd0, err}, 32'd0);
        resetn = 1'b1;
        tick();

        setf(4'd1, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF);
        send("addi", 32'hFFF0_0293, 1'b1, 1'b0);
        chk("addi.rdy_next", {31'd0, rr}, 32'd1);
        drain("addi");

        li2("li_big", 5'd1, 32'h1234_5678, 32'h1234_50B7, 32'h6780_8093);
        li2("li_800", 5'd1, 32'h0000_0800, 32'h0000_10B7, 32'h8000_8093);
        li2("li_wrap", 5'd1, 32'h7FFF_F800, 32'h8000_00B7, 32'h8000_8093);

        setf(4'd11, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_5000);
        send("li_lui", 32'h0000_5137, 1'b1, 1'b0);
        drain("li_lui");
        setf(4'd11, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF);
        send("li_small", 32'hFFF0_0093, 1'b1, 1'b0);
        drain("li_small");
        setf(4'd11, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_F800);
        send("li_min", 32'h8000_0193, 1'b1, 1'b0);
        drain("li_min");

        setf(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
        send("sub", 32'h4020_81B3, 1'b1, 1'b0);
        drain("sub");
        setf(4'd1, 5'd5, 5'd5, 5'd0, 3'd5, 1'b1, 32'd3);
        send("srai", 32'h4032_D293, 1'b1, 1'b0);
        drain("srai");
        setf(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8);
        send("sw", 32'h0020_A423, 1'b1, 1'b0);
        drain("sw");
        setf(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8);
        send("beq", 32'h0020_8463, 1'b1, 1'b0);
        drain("beq");
        setf(4'd5, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFC);
        send("jal", 32'hFFDF_F06F, 1'b1, 1'b0);
        drain("jal");
        setf(4'd8, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E123);
        send("auipc", 32'hABCD_E217, 1'b1, 1'b0);
        drain("auipc");

        setf(4'd10, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
`ifdef INSTR_ENCODER_MULDIV_EN
        send("mul", 32'h0220_81B3, 1'b1, 1'b0);
`else
        send("mul", 32'h0000_0013, 1'b1, 1'b1);
`endif
        drain("mul");
        setf(4'd15, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
        send("bad", 32'h0000_0013, 1'b1, 1'b1);
        drain("bad");
        chk("bad.err_clr", {31'd0, err}, 32'd0);
        setf(4'd12, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
        send("nop", 32'h0000_0013, 1'b1, 1'b0);
        drain("nop");

        setf(4'd1, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7);
        rv = 1'b1;
        tick();
        chk("b2b.a", d, 32'h0070_0313);
        chk("b2b.rdy", {31'd0, rr}, 32'd1);
        setf(4'd1, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'd9);
        tick();
        rv = 1'b0;
        chk("b2b.b", d, 32'h0090_0393);
        chk("b2b.bv", {31'd0, iv}, 32'd1);
        drain("b2b");

        ir = 1'b0;
        setf(4'd11, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5678);
        send("bp.w1", 32'h1234_50B7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp.hold_d", d, 32'h1234_50B7);
            chk("bp.hold_last", {31'd0, last}, 32'd0);
        end
        ir = 1'b1;
        tick();
        ir = 1'b0;
        chk("bp.w2", d, 32'h6780_8093);
        tick();
        chk("bp.w2_hold", d, 32'h6780_8093);
        chk("bp.w2_v", {31'd0, iv}, 32'd1);
        ir = 1'b1;
        drain("bp");

        setf(4'd11, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5678);
        send("rst2.w1", 32'h1234_50B7, 1'b0, 1'b0);
        ir = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        chk("rst2.v", {31'd0, iv}, 32'd0);
        chk("rst2.d", d, 32'h0000_0013);
        tick();
        resetn = 1'b1;
        ir = 1'b1;
        tick();
        chk("rst2.no_w2", {31'd0, iv}, 32'd0);
        tick();
        chk("rst2.no_w2b", {31'd0, iv}, 32'd0);
        chk("rst2.rdy", {31'd0, rr}, 32'd1);

        setf(4'd11, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_5000);
        rv1 = 1'b1;
        tick();
        rv1 = 1'b0;
        chk("fix.w1", d1, 32'h0000_5137);
        chk("fix.last1", {31'd0, last1}, 32'd0);
        tick();
        chk("fix.w2", d1, 32'h0001_0113);
        chk("fix.last2", {31'd0, last1}, 32'd1);
        tick();
        chk("fix.idle", {31'd0, iv1}, 32'd0);
        setf(4'd11, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF);
        rv1 = 1'b1;
        tick();
        rv1 = 1'b0;
        chk("fix_s.w1", d1, 32'h0000_00B7);
        tick();
        chk("fix_s.w2", d1, 32'hFFF0_8093);
        tick();
        chk("fix_s.idle", {31'd0, iv1}, 32'd0);
        chk("fix.err", {31'd0, err1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
